// File: rtl/sram_stream_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_stream_reader: SRAM read master streaming a command's words through a
// 2-entry output buffer with last-beat marking.                    Rev 1.0
// ---------------------------------------------------------------------------
module sram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clka,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] tail_data;
  logic                  head_last;
  logic                  tail_last;

  logic       accept;
  logic       pop;
  logic       final_issue;
  logic [2:0] occ;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign m_valid   = (buf_cnt != 2'd0);
  assign m_data    = head_data;
  assign m_last    = head_last;
  assign pop       = m_valid & m_ready;

  // Occupancy the buffer will hold after this edge; a read issued now lands one cycle later,
  // so keeping this below 2 is what guarantees the buffer never overflows.
  assign occ         = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign mem_en      = (state == RUN) && (remaining != '0) && (occ < 3'd2);
  assign final_issue = mem_en && (remaining == (ADDR_WIDTH+1)'(1));

  always_ff @(posedge clka) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      mem_addr  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            mem_addr  <= cmd_addr;
            remaining <= cmd_len;
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (mem_en) begin
            mem_addr  <= mem_addr + ADDR_WIDTH'(1);
            remaining <= remaining - (ADDR_WIDTH+1)'(1);
            if (final_issue) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      buf_cnt       <= 2'd0;
      head_data     <= '0;
      tail_data     <= '0;
      head_last     <= 1'b0;
      tail_last     <= 1'b0;
    end else begin
      inflight      <= mem_en;
      inflight_last <= final_issue;
      unique case ({inflight, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            head_data <= mem_rdata;
            head_last <= inflight_last;
          end else begin
            tail_data <= mem_rdata;
            tail_last <= inflight_last;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_last <= tail_last;
          buf_cnt   <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            head_data <= mem_rdata;
            head_last <= inflight_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= mem_rdata;
            tail_last <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_stream_reader.sv
`default_nettype none
// Scoreboard bench for sram_stream_reader: SRAM model, address-order reference, decoupled monitor.
module tb_sram_stream_reader;
  localparam int AW    = 10;
  localparam int DW    = 256;
  localparam int DEPTH = 1 << AW;

  logic          clka = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          done;

  sram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clka(clka), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .done(done)
  );

  always #5 clka = ~clka;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clka) if (mem_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];
  logic [AW-1:0] exp_addr[$];

  int   ready_mode = 0;
  logic drv_done_flag = 1'b0;
  logic mon_done_prev = 1'b0;
  int   issued = 0, popped = 0;
  int   hs_cyc = 0, first_valid_cyc = -1, last_beat_cyc = 0, beat_cnt = 0, last_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev;
  logic          last_prev;
  logic          pop_now;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  initial forever begin
    @(posedge clka);
    #1;
    m_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every accepted beat and checks issue/done behaviour.
  always @(negedge clka) begin
    if (reset) begin
      exp_data.delete();
      exp_last.delete();
      exp_addr.delete();
      issued        = 0;
      popped        = 0;
      stall_prev    = 1'b0;
      mon_done_prev = 1'b0;
      drv_done_flag = 1'b0;
    end else begin
      if (done || mon_done_prev || drv_done_flag)
        check("done", done, mon_done_prev | drv_done_flag);
      mon_done_prev = 1'b0;
      drv_done_flag = 1'b0;
      pop_now = m_valid & m_ready;
      if (mem_en) begin
        if (exp_addr.size() == 0) fail_now("unexpected_mem_en");
        else check("mem_addr", mem_addr, exp_addr.pop_front());
        check("issue_room", ((issued - popped + 1 - int'(pop_now)) <= 2), 1);
      end
      if (m_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stall_prev) begin
          check("hold_data", m_data, data_prev);
          check("hold_last", m_last, last_prev);
        end
        if (m_ready) begin
          if (exp_data.size() == 0) begin
            fail_now("unexpected_beat");
          end else begin
            check("m_data", m_data, exp_data.pop_front());
            check("m_last", m_last, exp_last.pop_front());
          end
          beat_cnt++;
          last_beat_cyc = cyc;
          if (m_last) begin
            last_cnt++;
            mon_done_prev = 1'b1;
          end
        end
      end
      stall_prev = m_valid & ~m_ready;
      data_prev  = m_data;
      last_prev  = m_last;
      issued += int'(mem_en);
      popped += int'(pop_now);
    end
  end

  task automatic send_cmd(input int a, input int len);
    int n;
    @(posedge clka);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = AW'(a);
    cmd_len   = (AW+1)'(len);
    n = 0;
    @(negedge clka);
    while (!cmd_ready) begin
      n++;
      if (n > 5000) begin
        fail_now("cmd_ready_timeout");
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clka);
    end
    hs_cyc = cyc;
    @(posedge clka);
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(AW'((a + i) % DEPTH));
      exp_data.push_back(mem[(a + i) % DEPTH]);
      exp_last.push_back(i == len - 1);
    end
    if (len == 0) drv_done_flag = 1'b1;
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_data.size() != 0 || !cmd_ready) && n < 5000) begin
      @(negedge clka);
      n++;
    end
    if (n >= 5000) fail_now("idle_timeout");
    repeat (3) @(negedge clka);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    repeat (3) @(posedge clka);
    @(negedge clka);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_done", done, 0);
    @(posedge clka);
    #1 reset = 1'b0;

    // Basic latency and ordering
    first_valid_cyc = -1;
    beat_cnt = 0;
    send_cmd(5, 4);
    wait_idle();
    check("latency", 32'(first_valid_cyc - hs_cyc), 3);
    check("t1_beats", beat_cnt, 4);
    check("t1_span", 32'(last_beat_cyc - first_valid_cyc), 3);

    // Address wrap
    send_cmd(1020, 8);
    wait_idle();

    // Random back-pressure
    ready_mode = 1;
    send_cmd(100, 16);
    wait_idle();
    ready_mode = 0;

    // Zero-length command
    send_cmd(7, 0);
    wait_idle();

    // Reset mid-command
    beat_cnt = 0;
    send_cmd(0, 64);
    begin
      int n;
      n = 0;
      while (beat_cnt < 10 && n < 1000) begin
        @(negedge clka);
        n++;
      end
      if (n >= 1000) fail_now("beat10_timeout");
    end
    @(posedge clka);
    #1 reset = 1'b1;
    @(posedge clka);
    #1 reset = 1'b0;
    @(negedge clka);
    check("abort_m_valid", m_valid, 0);
    check("abort_mem_en", mem_en, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_done", done, 0);
    send_cmd(0, 2);
    wait_idle();

    // Full-depth sweep at full rate
    first_valid_cyc = -1;
    beat_cnt = 0;
    last_cnt = 0;
    send_cmd(0, DEPTH);
    wait_idle();
    check("sweep_beats", beat_cnt, DEPTH);
    check("sweep_span", 32'(last_beat_cyc - first_valid_cyc), DEPTH - 1);
    check("sweep_lasts", last_cnt, 1);

    // Randomised commands over random SRAM contents
    for (int i = 0; i < DEPTH; i++)
      for (int w = 0; w < DW / 32; w++) mem[i][w*32 +: 32] = $urandom;
    for (int k = 0; k < 24; k++) begin
      ready_mode = int'($urandom_range(0, 1));
      send_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)));
    end
    wait_idle();
    ready_mode = 0;
    check("scoreboard_empty", exp_data.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
